// File: rtl/chip8_pc_pkg.sv
// Shared types and constants for the CHIP-8 program-counter sequencer.
package chip8_pc_pkg;

  localparam int PC_W = 12;

  localparam logic [1:0] STK_IDLE = 2'b00;
  localparam logic [1:0] STK_PUSH = 2'b01;
  localparam logic [1:0] STK_POP  = 2'b10;

  typedef enum logic [2:0] {
    CMD_NEXT = 3'd0,
    CMD_SKIP = 3'd1,
    CMD_JUMP = 3'd2,
    CMD_CALL = 3'd3,
    CMD_RET  = 3'd4
  } pc_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH,
    ST_POP,
    ST_WAIT,
    ST_LOAD,
    ST_FAULT
  } pc_state_e;

endpackage

// File: rtl/chip8_pc_sequencer.sv
// PC and call/return sequencer feeding Chip8_Stack.
// Define CHIP8_STACK_GUARD_EN to enable depth tracking and the over/underflow FAULT state.
module chip8_pc_sequencer
  import chip8_pc_pkg::*;
#(
  parameter int unsigned     STACK_DEPTH  = 16,
  parameter int unsigned     STACK_RD_LAT = 1,
  parameter logic [PC_W-1:0] PC_RESET     = 12'h200
) (
  input  logic            cpu_clk,
  input  logic            reset,
  input  logic            cmd_valid,
  input  logic [2:0]      cmd,
  input  logic [PC_W-1:0] target,
  output logic            ready,
  output logic            done,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      stk_we,
  output logic [15:0]     stk_writedata,
  input  logic [15:0]     stk_outdata,
  output logic [4:0]      depth,
  output logic            fault
);

  pc_state_e       state;
  pc_cmd_e         cmd_e;
  logic [PC_W-1:0] target_q;
  logic [1:0]      wait_cnt;
  logic            accept;
  logic            call_blocked;
  logic            ret_blocked;
  logic            unused_outdata;

  assign cmd_e          = pc_cmd_e'(cmd);
  assign ready          = (state == ST_IDLE);
  assign accept         = cmd_valid && ready;
  assign unused_outdata = ^stk_outdata[15:PC_W];

  always_comb begin
    stk_we = STK_IDLE;
    case (state)
      ST_PUSH: stk_we = STK_PUSH;
      ST_POP:  stk_we = STK_POP;
      default: stk_we = STK_IDLE;
    endcase
  end

`ifdef CHIP8_STACK_GUARD_EN
  logic [4:0] depth_q;
  logic       fault_q;

  assign call_blocked = (32'(depth_q) == STACK_DEPTH);
  assign ret_blocked  = (depth_q == 5'd0);
  assign depth        = depth_q;
  assign fault        = fault_q;

  // Occupancy follows the actual stack strobes, so it moves exactly once per push/pop.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      depth_q <= 5'd0;
      fault_q <= 1'b0;
    end else begin
      if (state == ST_PUSH) begin
        depth_q <= depth_q + 5'd1;
      end else if (state == ST_POP) begin
        depth_q <= depth_q - 5'd1;
      end
      if (accept && ((cmd_e == CMD_CALL && call_blocked) ||
                     (cmd_e == CMD_RET && ret_blocked))) begin
        fault_q <= 1'b1;
      end
    end
  end
`else
  logic unused_depth_param;

  assign call_blocked       = 1'b0;
  assign ret_blocked        = 1'b0;
  assign depth              = 5'd0;
  assign fault              = 1'b0;
  assign unused_depth_param = STACK_DEPTH[0];
`endif

  // Only one command is ever in flight; done is a one-cycle pulse after the pc update.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      pc            <= PC_RESET;
      done          <= 1'b0;
      stk_writedata <= 16'h0000;
      target_q      <= '0;
      wait_cnt      <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (cmd_e)
              CMD_SKIP: begin
                pc   <= pc + 12'd4;
                done <= 1'b1;
              end
              CMD_JUMP: begin
                pc   <= target;
                done <= 1'b1;
              end
              CMD_CALL: begin
                if (call_blocked) begin
                  state <= ST_FAULT;
                end else begin
                  stk_writedata <= {4'h0, pc + 12'd2};
                  target_q      <= target;
                  state         <= ST_PUSH;
                end
              end
              CMD_RET: begin
                state <= ret_blocked ? ST_FAULT : ST_POP;
              end
              default: begin
                pc   <= pc + 12'd2;
                done <= 1'b1;
              end
            endcase
          end
        end
        ST_PUSH: begin
          pc    <= target_q;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        ST_POP: begin
          if (STACK_RD_LAT <= 1) begin
            state <= ST_LOAD;
          end else begin
            wait_cnt <= 2'(STACK_RD_LAT - 2);
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 2'd0) begin
            state <= ST_LOAD;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ST_LOAD: begin
          pc    <= stk_outdata[PC_W-1:0];
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= state;
      endcase
    end
  end

endmodule
